// File: rtl/sampler_word.sv
// sampler_word: XORed ring-oscillator entropy sampler with optional von Neumann
// debiasing, repetition-count health test and MSB-first word packing.
// Words leave on a valid/ready handshake; sampling pauses while a word is held.

// Behavioural ring-oscillator stand-in: an LFSR stepped on every rising ctrl edge.
module ro_sim #(
  parameter logic [7:0] SEED = 8'h81
) (
  input  logic ctrl,
  input  logic rst_n,
  output logic ro_out
);

  logic [7:0] lfsr_q;

  // Step the LFSR on each ring "oscillation" edge
  always_ff @(posedge ctrl or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign ro_out = lfsr_q[7];

endmodule

module sampler_word #(
  parameter int NUM_RINGS     = 14,
  parameter int WORD_WIDTH    = 32,
  parameter int SAMPLE_DIV    = 4,
  parameter int WARMUP_CYCLES = 64,
  parameter int RUN_LIMIT     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  debias_en,
  input  logic                  test_en,
  input  logic                  test_bit,
  input  logic                  word_ready,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_valid,
  output logic                  health_fail,
  output logic                  busy
);

  localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BW = $clog2(WORD_WIDTH);
  localparam int RW = $clog2(RUN_LIMIT + 1);

  localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_WIDTH - 1);
  localparam logic [RW-1:0] RUN_MAX   = RW'(RUN_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_COLLECT = 3'd2,
    S_HOLD    = 3'd3,
    S_FAIL    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    debias_q, debias_d;
  logic                    test_q, test_d;
  logic                    ring_en_q, ring_en_d;
  logic [WW-1:0]           warm_cnt_q, warm_cnt_d;
  logic [DW-1:0]           div_cnt_q, div_cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0]   sr_q, sr_d;
  logic                    pair_vld_q, pair_vld_d;
  logic                    pair_bit_q, pair_bit_d;
  logic [RW-1:0]           run_cnt_q, run_cnt_d;
  logic                    prev_q, prev_d;
  logic [WORD_WIDTH-1:0]   word_data_q, word_data_d;
  logic                    word_valid_q, word_valid_d;
  logic                    health_fail_q, health_fail_d;
  logic [1:0]              sync_q;

  logic                    strobe;
  logic                    acc_vld;
  logic                    acc_bit;
  logic                    trip;
  logic                    enter_collect;
  logic                    raw_s;
  logic                    raw_in;

  // ---------------- ring bank ----------------
  (* keep = "true" *) logic [NUM_RINGS-1:0] ring_ctrl;
  (* keep = "true" *) logic [NUM_RINGS-1:0] ring_out;
  (* keep = "true" *) logic                 ring_xor;

  for (genvar i = 0; i < NUM_RINGS; i++) begin : g_ring
    // Alternate clock phases so neighbouring rings do not step in lockstep
    if ((i % 2) == 0) begin : g_even
      assign ring_ctrl[i] = clk & ring_en_q;
    end else begin : g_odd
      assign ring_ctrl[i] = ~clk & ring_en_q;
    end
    ro_sim #(.SEED({1'b1, 7'(i)})) u_ro (
      .ctrl   (ring_ctrl[i]),
      .rst_n  (rst_n),
      .ro_out (ring_out[i])
    );
  end

  assign ring_xor = ^ring_out;
  assign raw_in   = test_q ? test_bit : ring_xor;
  assign raw_s    = sync_q[1];

  // Two-flop synchroniser for the asynchronous raw bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], raw_in};
  end

  // Next-state, sampling, debias, health and packing logic
  always_comb begin
    state_d       = state_q;
    debias_d      = debias_q;
    test_d        = test_q;
    warm_cnt_d    = warm_cnt_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    sr_d          = sr_q;
    pair_vld_d    = pair_vld_q;
    pair_bit_d    = pair_bit_q;
    run_cnt_d     = run_cnt_q;
    prev_d        = prev_q;
    word_data_d   = word_data_q;
    word_valid_d  = word_valid_q;
    health_fail_d = health_fail_q;
    strobe        = 1'b0;
    acc_vld       = 1'b0;
    acc_bit       = 1'b0;
    trip          = 1'b0;
    enter_collect = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          debias_d      = debias_en;
          test_d        = test_en;
          health_fail_d = 1'b0;
          run_cnt_d     = '0;
          warm_cnt_d    = '0;
          if (WARMUP_CYCLES == 0) begin
            state_d       = S_COLLECT;
            enter_collect = 1'b1;
          end else begin
            state_d = S_WARMUP;
          end
        end
      end

      S_WARMUP: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (warm_cnt_q == WARM_LAST) begin
          state_d       = S_COLLECT;
          enter_collect = 1'b1;
        end else begin
          warm_cnt_d = warm_cnt_q + WW'(1);
        end
      end

      S_COLLECT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          if (div_cnt_q == DIV_LAST) begin
            strobe    = 1'b1;
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q + DW'(1);
          end

          if (strobe) begin
            // Repetition count on raw samples; zero means no previous sample yet
            prev_d = raw_s;
            if (run_cnt_q == '0 || raw_s != prev_q) begin
              run_cnt_d = RW'(1);
            end else if (run_cnt_q != RUN_MAX) begin
              run_cnt_d = run_cnt_q + RW'(1);
            end
            trip = (run_cnt_d == RUN_MAX);

            // Von Neumann: first of an unequal pair is the output bit
            if (debias_q) begin
              if (!pair_vld_q) begin
                pair_vld_d = 1'b1;
                pair_bit_d = raw_s;
              end else begin
                pair_vld_d = 1'b0;
                if (pair_bit_q != raw_s) begin
                  acc_vld = 1'b1;
                  acc_bit = pair_bit_q;
                end
              end
            end else begin
              acc_vld = 1'b1;
              acc_bit = raw_s;
            end

            // A health trip overrides word completion and drops the partial word
            if (trip) begin
              state_d       = S_FAIL;
              health_fail_d = 1'b1;
              bit_cnt_d     = '0;
              sr_d          = '0;
            end else if (acc_vld) begin
              if (bit_cnt_q == BIT_LAST) begin
                word_data_d  = {sr_q[WORD_WIDTH-2:0], acc_bit};
                word_valid_d = 1'b1;
                state_d      = S_HOLD;
                bit_cnt_d    = '0;
                sr_d         = '0;
              end else begin
                sr_d      = {sr_q[WORD_WIDTH-2:0], acc_bit};
                bit_cnt_d = bit_cnt_q + BW'(1);
              end
            end
          end
        end
      end

      S_HOLD: begin
        if (word_valid_q && word_ready) begin
          word_valid_d = 1'b0;
          if (enable) begin
            state_d       = S_COLLECT;
            enter_collect = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_FAIL: begin
        word_valid_d = 1'b0;
        if (!enable) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every COLLECT entry starts a fresh divider phase, pair and word
    if (enter_collect) begin
      div_cnt_d  = '0;
      pair_vld_d = 1'b0;
      bit_cnt_d  = '0;
      sr_d       = '0;
    end

    ring_en_d = ((state_d == S_WARMUP) || (state_d == S_COLLECT) || (state_d == S_HOLD)) && !test_d;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      debias_q      <= 1'b0;
      test_q        <= 1'b0;
      ring_en_q     <= 1'b0;
      warm_cnt_q    <= '0;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      sr_q          <= '0;
      pair_vld_q    <= 1'b0;
      pair_bit_q    <= 1'b0;
      run_cnt_q     <= '0;
      prev_q        <= 1'b0;
      word_data_q   <= '0;
      word_valid_q  <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      debias_q      <= debias_d;
      test_q        <= test_d;
      ring_en_q     <= ring_en_d;
      warm_cnt_q    <= warm_cnt_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      sr_q          <= sr_d;
      pair_vld_q    <= pair_vld_d;
      pair_bit_q    <= pair_bit_d;
      run_cnt_q     <= run_cnt_d;
      prev_q        <= prev_d;
      word_data_q   <= word_data_d;
      word_valid_q  <= word_valid_d;
      health_fail_q <= health_fail_d;
    end
  end

  assign word_data   = word_data_q;
  assign word_valid  = word_valid_q;
  assign health_fail = health_fail_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sampler_word.sv
// Directed bench for sampler_word in test mode: reset, packing, backpressure,
// HOLD release, debias, health trip and abort, each with hand-computed results.
`timescale 1ns/1ps
module tb_sampler_word;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       debias_en;
  logic       test_en;
  logic       test_bit;
  logic       word_ready;
  logic [7:0] word_data;
  logic       word_valid;
  logic       health_fail;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  sampler_word #(
    .NUM_RINGS     (3),
    .WORD_WIDTH    (8),
    .SAMPLE_DIV    (1),
    .WARMUP_CYCLES (4),
    .RUN_LIMIT     (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .debias_en   (debias_en),
    .test_en     (test_en),
    .test_bit    (test_bit),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .health_fail (health_fail),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives seq MSB-first from offset start_off, one bit per clock, and waits
  // (bounded by max_off) for word_valid; reports the offset it appeared at.
  task automatic run_stream(input logic [31:0] seq, input int n, input int start_off,
                            input int max_off, output int valid_at, output logic [7:0] data);
    valid_at = -1;
    data     = 8'h00;
    for (int off = 0; off <= max_off; off++) begin
      if (off > start_off && word_valid === 1'b1) begin
        valid_at = off;
        data     = word_data;
        break;
      end
      if (off >= start_off && off < start_off + n) test_bit = seq[n - 1 - (off - start_off)];
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    enable     = 1'b1;
    debias_en  = 1'($urandom_range(0, 1));
    test_en    = 1'($urandom_range(0, 1));
    test_bit   = 1'($urandom_range(0, 1));
    word_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      tick();
      test_bit   = 1'($urandom_range(0, 1));
      word_ready = 1'($urandom_range(0, 1));
    end
    compared++;
    if (word_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", word_valid); end
    compared++;
    if (word_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h expected 00", word_data); end
    compared++;
    if (health_fail !== 1'b0) begin mismatched++; $display("FAIL reset_health: got %b expected 0", health_fail); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
    test_en    = 1'b1;
    debias_en  = 1'b0;
    word_ready = 1'b0;
    test_bit   = 1'b0;
    rst_n      = 1'b1;
  endtask

  // Starts right after reset release with enable already high
  task automatic test_packing();
    int         va;
    logic [7:0] d;
    run_stream(32'b10110010, 8, 3, 40, va, d);
    compared++;
    if (va !== 13) begin mismatched++; $display("FAIL pack_latency: got %0d expected 13", va); end
    compared++;
    if (d !== 8'hB2) begin mismatched++; $display("FAIL pack_data: got %h expected b2", d); end
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL pack_busy: got %b expected 1", busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] alt;
    alt        = 8'b01010101;
    word_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      test_bit = 1'($urandom_range(0, 1));
      tick();
      compared++;
      if ({word_valid, word_data} !== {1'b1, 8'hB2}) begin
        mismatched++;
        $display("FAIL hold_stable[%0d]: got valid=%b data=%h expected valid=1 data=b2", i, word_valid, word_data);
      end
    end
    test_bit = alt[7];
    tick();
    test_bit   = alt[6];
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    compared++;
    if (word_valid !== 1'b0) begin mismatched++; $display("FAIL hold_release_valid: got %b expected 0", word_valid); end
    for (int k = 2; k < 8; k++) begin
      test_bit = alt[7 - k];
      tick();
    end
    tick();
    compared++;
    if (word_valid !== 1'b0) begin mismatched++; $display("FAIL alt_early_valid: got %b expected 0", word_valid); end
    tick();
    compared++;
    if ({word_valid, word_data} !== {1'b1, 8'h55}) begin
      mismatched++;
      $display("FAIL alt_word: got valid=%b data=%h expected valid=1 data=55", word_valid, word_data);
    end
  endtask

  task automatic test_hold_disable();
    enable = 1'b0;
    tick();
    tick();
    compared++;
    if ({busy, word_valid, word_data} !== {1'b1, 1'b1, 8'h55}) begin
      mismatched++;
      $display("FAIL hold_disable: got busy=%b valid=%b data=%h expected busy=1 valid=1 data=55", busy, word_valid, word_data);
    end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    compared++;
    if ({busy, word_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL hold_disable_idle: got busy=%b valid=%b expected busy=0 valid=0", busy, word_valid);
    end
  endtask

  task automatic test_debias();
    int         va;
    logic [7:0] d;
    debias_en = 1'b1;
    test_en   = 1'b1;
    enable    = 1'b1;
    tick();
    debias_en = 1'b0;  // ignored outside IDLE
    run_stream(32'b01_10_00_11_10_01_10_10_01_01, 20, 2, 60, va, d);
    compared++;
    if (va !== 24) begin mismatched++; $display("FAIL debias_latency: got %0d expected 24", va); end
    compared++;
    if (d !== 8'h6C) begin mismatched++; $display("FAIL debias_data: got %h expected 6c", d); end
    enable     = 1'b0;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL debias_exit_busy: got %b expected 0", busy); end
  endtask

  task automatic test_health();
    test_bit  = 1'b1;
    debias_en = 1'b0;
    enable    = 1'b1;
    for (int off = 1; off <= 12; off++) tick();
    compared++;
    if (health_fail !== 1'b0) begin mismatched++; $display("FAIL health_early: got %b expected 0", health_fail); end
    tick();
    compared++;
    if ({health_fail, word_valid, busy} !== 3'b101) begin
      mismatched++;
      $display("FAIL health_trip: got fail=%b valid=%b busy=%b expected fail=1 valid=0 busy=1", health_fail, word_valid, busy);
    end
    for (int i = 0; i < 3; i++) tick();
    compared++;
    if ({health_fail, word_valid, busy} !== 3'b101) begin
      mismatched++;
      $display("FAIL health_in_fail: got fail=%b valid=%b busy=%b expected fail=1 valid=0 busy=1", health_fail, word_valid, busy);
    end
    enable = 1'b0;
    tick();
    compared++;
    if ({health_fail, busy} !== 2'b10) begin
      mismatched++;
      $display("FAIL health_sticky: got fail=%b busy=%b expected fail=1 busy=0", health_fail, busy);
    end
    enable = 1'b1;
    tick();
    compared++;
    if ({health_fail, busy} !== 2'b01) begin
      mismatched++;
      $display("FAIL health_clear: got fail=%b busy=%b expected fail=0 busy=1", health_fail, busy);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int         va;
    logic [7:0] d;
    logic [4:0] old_bits;
    old_bits  = 5'b11010;
    debias_en = 1'b0;
    test_en   = 1'b1;
    enable    = 1'b1;
    for (int off = 1; off <= 10; off++) begin
      tick();
      if (off >= 3 && off <= 7) test_bit = old_bits[7 - off];
    end
    enable = 1'b0;
    tick();
    compared++;
    if ({busy, word_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL abort_busy: got busy=%b valid=%b expected busy=0 valid=0", busy, word_valid);
    end
    enable = 1'b1;
    run_stream(32'b00111100, 8, 3, 40, va, d);
    compared++;
    if (va !== 13) begin mismatched++; $display("FAIL abort_latency: got %0d expected 13", va); end
    compared++;
    if (d !== 8'h3C) begin mismatched++; $display("FAIL abort_data: got %h expected 3c", d); end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_backpressure();
    test_hold_disable();
    test_debias();
    test_health();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
